// File: rtl/usb_tx_fifo_if.sv
// Handshake bundle between host logic / transmitter and the usb_tx_fifo packet buffer.
interface usb_tx_fifo_if #(
    parameter int ADDR_BITS = 6
) ();
    logic                 clear;
    logic                 w_enable;
    logic [7:0]           w_data;
    logic                 commit;
    logic                 r_enable;
    logic                 is_txing;
    logic [7:0]           r_data;
    logic                 send_data;
    logic                 full;
    logic                 empty;
    logic [ADDR_BITS:0]   count;
    logic                 err;

    modport master (
        output clear, w_enable, w_data, commit, r_enable, is_txing,
        input  r_data, send_data, full, empty, count, err
    );

    modport slave (
        input  clear, w_enable, w_data, commit, r_enable, is_txing,
        output r_data, send_data, full, empty, count, err
    );
endinterface

// File: rtl/usb_tx_fifo.sv
// Transmit packet buffer: circular byte store plus commit/send sequencer for the USB transmitter.
// Optional CRC-16/USB trailer appended on commit when USB_TX_FIFO_CRC16_EN is defined.
module usb_tx_fifo #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic          clk,
    input  logic          n_rst,
    usb_tx_fifo_if.slave  bus
);
    typedef logic [ADDR_BITS:0]   cnt_t;
    typedef logic [ADDR_BITS-1:0] ptr_t;
    typedef enum logic [2:0] {IDLE, CRC_LO, CRC_HI, ARM, WAIT_TX, BUSY} state_t;

    logic [7:0] mem [DEPTH];
    ptr_t       wptr, rptr;
    cnt_t       count;
    state_t     state;
    logic       err, send_data;
    logic       full, empty, in_crc;
    logic       wr_ok, host_wr_ok, rd_ok, commit_ok, commit_rej, err_set;
    logic [7:0] wr_byte;

`ifdef USB_TX_FIFO_CRC16_EN
    logic [15:0] crc;

    // Reflected 0x8005 (0xA001), one byte LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction
`endif

    assign full   = (count == cnt_t'(DEPTH));
    assign empty  = (count == '0);
    assign in_crc = (state == CRC_LO) || (state == CRC_HI);

    // NOTE: every signal gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        rd_ok      = bus.r_enable && !empty;
        host_wr_ok = bus.w_enable && (!full || bus.r_enable) && !in_crc;
        wr_ok      = host_wr_ok;
        wr_byte    = bus.w_data;
        commit_ok  = (state == IDLE) && bus.commit && !empty;
        commit_rej = 1'b0;
`ifdef USB_TX_FIFO_CRC16_EN
        commit_rej = commit_ok && (count > cnt_t'(DEPTH - 2));
        commit_ok  = commit_ok && !commit_rej;
        if (in_crc) begin
            wr_ok   = !full || rd_ok;
            wr_byte = (state == CRC_LO) ? ~crc[7:0] : ~crc[15:8];
        end
`endif
        err_set = (bus.w_enable && full && !bus.r_enable)
               || (bus.r_enable && empty)
               || (bus.w_enable && in_crc)
               || (in_crc && !wr_ok)
               || commit_rej;
    end

    // NOTE: the byte array has no reset; its contents are don't-care until written, and a reset here would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.clear) mem[wptr] <= wr_byte;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            err       <= 1'b0;
            state     <= IDLE;
            send_data <= 1'b0;
`ifdef USB_TX_FIFO_CRC16_EN
            crc       <= 16'hFFFF;
`endif
        end else if (bus.clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            err       <= 1'b0;
            state     <= IDLE;
            send_data <= 1'b0;
`ifdef USB_TX_FIFO_CRC16_EN
            crc       <= 16'hFFFF;
`endif
        end else begin
            if (wr_ok) wptr <= wptr + ptr_t'(1);
            if (rd_ok) rptr <= rptr + ptr_t'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
            err       <= err | err_set;
            send_data <= 1'b0;
`ifdef USB_TX_FIFO_CRC16_EN
            if (state == CRC_HI)  crc <= 16'hFFFF;
            else if (host_wr_ok)  crc <= crc16_byte(crc, bus.w_data);
`endif
            case (state)
                IDLE: if (commit_ok) begin
`ifdef USB_TX_FIFO_CRC16_EN
                    state <= CRC_LO;
`else
                    state     <= ARM;
                    send_data <= 1'b1;
`endif
                end
                CRC_LO:  state <= CRC_HI;
                CRC_HI: begin
                    state     <= ARM;
                    send_data <= 1'b1;
                end
                ARM:     state <= WAIT_TX;
                WAIT_TX: if (bus.is_txing)  state <= BUSY;
                BUSY:    if (!bus.is_txing) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.r_data    = empty ? 8'hFF : mem[rptr];
    assign bus.send_data = send_data;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count;
    assign bus.err       = err;
endmodule

// File: tb/tb_usb_tx_fifo.sv
// Directed bench for usb_tx_fifo: vector table for single-cycle behaviour plus multi-cycle sequences.
module tb_usb_tx_fifo;
    localparam int DEPTH = 64;
    localparam int AB    = 6;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] q [$];

    usb_tx_fifo_if #(.ADDR_BITS(AB)) bus ();
    usb_tx_fifo #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       clr, we, re;
        logic [7:0] wd;
        logic [6:0] e_count;
        logic       e_empty, e_full, e_err;
        logic [7:0] e_rdata;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear = 0; bus.w_enable = 0; bus.w_data = 0;
        bus.commit = 0; bus.r_enable = 0; bus.is_txing = 0;
    endtask

    task automatic do_clear();
        bus.clear = 1; step(); bus.clear = 0;
        q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        bus.w_enable = 1; bus.w_data = b; step(); bus.w_enable = 0;
        q.push_back(b);
    endtask

    task automatic pop_check(input string name);
        check(name, {24'h0, bus.r_data}, {24'h0, q[0]});
        bus.r_enable = 1; step(); bus.r_enable = 0;
        void'(q.pop_front());
    endtask

    // Counts send_data pulses over n cycles; reports the first cycle index seen high.
    task automatic watch_send(input int n, output int pulses, output int first_at);
        pulses = 0; first_at = -1;
        for (int k = 0; k < n; k++) begin
            if (bus.send_data) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
            step();
        end
    endtask

    initial begin
        int pulses, first_at, exp_first, exp_cnt;
        idle_inputs();
        step(); step();
        n_rst = 1;
        step();

        // Reset asserted while byte 3 is being written.
        push(8'h01); push(8'h02);
        bus.w_enable = 1; bus.w_data = 8'h03;
        #3 n_rst = 0;
        #1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_rdata", 32'(bus.r_data), 32'hFF);
        check("rst_err", 32'(bus.err), 0);
        check("rst_send", 32'(bus.send_data), 0);
        bus.w_enable = 0;
        @(posedge clk); #1 n_rst = 1;
        step();
        check("rst_count_after", 32'(bus.count), 0);
        q.delete();

        //          clr we re wd     cnt emp ful err rdata
        vecs[0] = '{0, 0, 0, 8'h00, 0,  1,  0,  0,  8'hFF};
        vecs[1] = '{0, 1, 0, 8'h11, 1,  0,  0,  0,  8'h11};
        vecs[2] = '{0, 1, 0, 8'h22, 2,  0,  0,  0,  8'h11};
        vecs[3] = '{0, 0, 1, 8'h00, 1,  0,  0,  0,  8'h22};
        vecs[4] = '{0, 1, 1, 8'h33, 1,  0,  0,  0,  8'h33};
        vecs[5] = '{0, 0, 1, 8'h00, 0,  1,  0,  0,  8'hFF};
        vecs[6] = '{0, 0, 1, 8'h00, 0,  1,  0,  1,  8'hFF};
        vecs[7] = '{0, 1, 1, 8'h44, 1,  0,  0,  1,  8'h44};
        vecs[8] = '{1, 0, 0, 8'h00, 0,  1,  0,  0,  8'hFF};
        for (int i = 0; i < 9; i++) begin
            bus.clear = vecs[i].clr; bus.w_enable = vecs[i].we;
            bus.r_enable = vecs[i].re; bus.w_data = vecs[i].wd;
            step();
            idle_inputs();
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e_empty));
            check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_rdata", i), 32'(bus.r_data), 32'(vecs[i].e_rdata));
        end

        // Fill, overflow, drain, refill across the wrap.
        do_clear();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        check("fill_full", 32'(bus.full), 1);
        check("fill_count", 32'(bus.count), 64);
        bus.w_enable = 1; bus.w_data = 8'h40; step(); bus.w_enable = 0;
        check("ovf_err", 32'(bus.err), 1);
        check("ovf_count", 32'(bus.count), 64);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
        check("drain_empty", 32'(bus.empty), 1);
        for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
        check("refill_count", 32'(bus.count), 10);
        for (int i = 10; i < DEPTH; i++) push(8'(8'hC0 + i));
        check("refill_full", 32'(bus.full), 1);
        bus.w_enable = 1; bus.r_enable = 1; bus.w_data = 8'hA5; step();
        bus.w_enable = 0; bus.r_enable = 0;
        void'(q.pop_front()); q.push_back(8'hA5);
        check("fullrw_count", 32'(bus.count), 64);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("wrap%0d", i));
        check("wrap_empty", 32'(bus.empty), 1);

        // Commit handshake.
`ifdef USB_TX_FIFO_CRC16_EN
        exp_first = 2; exp_cnt = 4;
`else
        exp_first = 0; exp_cnt = 2;
`endif
        do_clear();
        push(8'h01); push(8'h02);
        bus.commit = 1; step(); bus.commit = 0;
        watch_send(6, pulses, first_at);
        check("hs_pulses", 32'(pulses), 1);
        check("hs_latency", 32'(first_at), 32'(exp_first));
        check("hs_count", 32'(bus.count), 32'(exp_cnt));
        bus.is_txing = 1; step();
        bus.commit = 1; step(); bus.commit = 0;
        watch_send(198, pulses, first_at);
        check("busy_commit_ignored", 32'(pulses), 0);
        check("busy_count", 32'(bus.count), 32'(exp_cnt));
        bus.is_txing = 0; step();
        bus.commit = 1; step(); bus.commit = 0;
        watch_send(6, pulses, first_at);
        check("idle_again_pulse", 32'(pulses), 1);

`ifdef USB_TX_FIFO_CRC16_EN
        // CRC trailer for "123456789": check value 0xB4C8, low byte first.
        do_clear();
        for (int i = 0; i < 9; i++) push(8'(8'h31 + i));
        bus.commit = 1; step(); bus.commit = 0;
        step(); step();
        check("crc_count", 32'(bus.count), 11);
        q.push_back(8'hC8); q.push_back(8'hB4);
        for (int i = 0; i < 11; i++) pop_check($sformatf("crc_pop%0d", i));
`endif

        // Clear wins over simultaneous write, commit and read.
        do_clear();
        bus.r_enable = 1; step(); bus.r_enable = 0;
        check("pre_clear_err", 32'(bus.err), 1);
        push(8'h10); push(8'h20);
        bus.clear = 1; bus.w_enable = 1; bus.w_data = 8'h77; bus.commit = 1; bus.r_enable = 1;
        step();
        idle_inputs();
        check("clr_count", 32'(bus.count), 0);
        check("clr_empty", 32'(bus.empty), 1);
        check("clr_err", 32'(bus.err), 0);
        check("clr_rdata", 32'(bus.r_data), 32'hFF);
        watch_send(5, pulses, first_at);
        check("clr_no_pulse", 32'(pulses), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_tx_fifo.md
# usb_tx_fifo

Transmit-side packet buffer that feeds the USB `transmitter`. Host logic writes payload bytes and commits a packet; the buffer then pulses `send_data` to the transmitter and presents bytes show-ahead on `r_data`, which drives `FIFO_byte`. It consumes the transmitter's `fifo_r_enable` pops and watches `is_txing` to sequence one packet at a time.

## Interface

**Parameters**
- `DEPTH`, 64: byte capacity; must be a power of two.
- `ADDR_BITS`, 6: log2(`DEPTH`).

**Ports** (clock and reset first)
- `clk` in 1: 96 MHz system clock.
- `n_rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `clear` in 1: synchronous flush.
- `w_enable` in 1: write strobe.
- `w_data` in 8: byte to write.
- `commit` in 1: marks the end of the packet currently in the buffer.
- `r_enable` in 1: pop strobe; connects to transmitter `fifo_r_enable`.
- `is_txing` in 1: transmitter busy flag.
- `r_data` out 8: head byte, show-ahead; connects to transmitter `FIFO_byte`.
- `send_data` out 1: one-cycle start pulse to the transmitter.
- `full` out 1: count == `DEPTH`.
- `empty` out 1: count == 0.
- `count` out `ADDR_BITS+1`: bytes currently stored.
- `err` out 1: sticky error flag.

## Operation

- **Storage.** Circular buffer of `DEPTH` bytes with `wptr`/`rptr` of `ADDR_BITS` width. Pointers wrap from `DEPTH-1` to 0.
- **`r_data`.** Equals `mem[rptr]` when not empty. Equals 8'hFF when empty.
- **Write.** Accepted when `w_enable` is high and either not full or `r_enable` is also high in the same cycle.
- **Read.** Accepted when `r_enable` is high and not empty.
- **Count update.** `count` changes by (write accepted) − (read accepted).
- **`err` set conditions** (sticky):
  - write while full with no concurrent read; the byte is dropped;
  - read while empty; the pop is ignored;
  - write during CRC_LO or CRC_HI; the byte is dropped;
  - commit rejected for lack of space (CRC build only).
- **`err` clear.** Cleared only by `clear` or reset.
- **FSM states.** IDLE, CRC_LO, CRC_HI, ARM, WAIT_TX, BUSY.
  - IDLE → ARM: `commit` && count > 0. In the CRC build this goes to CRC_LO instead.
  - `commit` is ignored when count == 0 or the state is not IDLE.
  - ARM: `send_data` = 1 for exactly this cycle; then go to WAIT_TX.
  - WAIT_TX → BUSY: when `is_txing` = 1.
  - BUSY → IDLE: when `is_txing` = 0.
- **Writes during transmission.** Writes in WAIT_TX and BUSY are allowed, so the next packet can accumulate.
- **`clear`.** Zeroes the pointers, count, CRC register and `err`, and forces IDLE. It has priority over every simultaneous event.
- **Reset.** Async reset produces the same state as `clear`. Memory contents are don't-care.

## Timing

- **Output reset values.** `r_data` = 8'hFF, `send_data` = 0, `full` = 0, `empty` = 1, `count` = 0, `err` = 0.
- **Write latency.** A byte written at edge N is visible on `r_data` and `count` after edge N; `empty` falls in the same cycle.
- **Pop.** `r_enable` sampled at edge N advances `rptr`, so the next byte appears after edge N.
- **Full and read together.** Both accepted; count is unchanged.
- **Empty and read/write together.** The write is accepted, the read is ignored, and `err` is set.
- **`send_data` latency.**
  - Without `CRC16_EN`: pulse is high during the cycle after the `commit` edge.
  - With `CRC16_EN`: 2 cycles later.
- **Stuck transmitter.** WAIT_TX waits indefinitely; `clear` is the only exit.

## Configuration

**Macro: `USB_TX_FIFO_CRC16_EN`**

With the macro defined:
- **CRC accumulation.** CRC-16/USB (polynomial 0x8005, reflected) is accumulated over every accepted write since the last commit or clear. Init is 16'hFFFF, LSB-first.
- **On commit.**
  - CRC_LO writes `~crc[7:0]` and CRC_HI writes `~crc[15:8]` into the buffer.
  - The CRC register then reinitialises and the FSM goes to ARM.
- **Space check.** `commit` requires count ≤ `DEPTH-2`. Otherwise the commit is rejected, `err` is set, and the state stays IDLE.

Without the macro:
- No CRC logic; CRC_LO and CRC_HI are unreachable.
- IDLE goes straight to ARM on commit.

## Test plan

- **Reset.** Assert `n_rst` mid-write of byte 3 → next cycle `count` = 0, `empty` = 1, `r_data` = 8'hFF, `err` = 0, `send_data` = 0.
- **Fill and wrap.**
  - Write 64 bytes 0x00..0x3F → `full` = 1, `count` = 64.
  - Write 0x40 → dropped, `err` = 1.
  - Pop 64 → `r_data` sequence 0x00..0x3F, then `empty` = 1.
  - Refill 10 bytes → correct bytes after pointer wrap.
- **Simultaneous ops.**
  - Full + read + write of 0xA5 → `count` stays 64; 0xA5 is the last byte popped.
  - Empty + read → `err` = 1, `count` = 0.
- **Handshake.**
  - Write 0x01 then 0x02, `commit` → `send_data` high for exactly 1 cycle.
  - Drive `is_txing` = 1 for 200 cycles, then 0 → FSM returns to IDLE.
  - A second `commit` during BUSY is ignored (no pulse).
- **CRC (`USB_TX_FIFO_CRC16_EN`).**
  - Write ASCII "123456789", `commit` → `count` = 11.
  - Pops yield the 9 data bytes, then 0xC8, then 0xB4 (check value 0xB4C8 after inversion).
  - `send_data` pulses 3 cycles after `commit`.
- **Clear priority.** `clear` asserted with `w_enable`, `commit` and `r_enable` all high → `count` = 0, no pulse, `err` = 0.
